mult_seq_n: RTL and testbench

MULT_SEQ_N -- requirements
Module: mult_seq_n

---
 rtl/mult_seq_n.sv | 122 ++++++++++++
 tb/tb_mult_seq_n.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_n.sv
// Sequential shift-add multiplier with signed/unsigned mode and fixed latency.
// Operands are captured as magnitudes; the result sign is applied in one extra cycle.
module mult_seq_n #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2:0]           state_o
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMPUTE = 3'd1,
        ST_SIGN    = 3'd2,
        ST_END     = 3'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign;
    logic [PW-1:0]      r_product;
    logic               r_busy;
    logic               r_done;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_last;

    // Negating in WIDTH bits maps -2^(WIDTH-1) onto the unsigned value 2^(WIDTH-1).
    assign w_a_neg = signed_i & a_i[WIDTH-1];
    assign w_b_neg = signed_i & b_i[WIDTH-1];
    assign w_a_mag = w_a_neg ? (WIDTH'(0) - a_i) : a_i;
    assign w_b_mag = w_b_neg ? (WIDTH'(0) - b_i) : b_i;
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    // Next-state logic; abort wins over every other transition while active.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start_i) w_next = ST_COMPUTE;
            ST_COMPUTE: begin
                if (abort_i)     w_next = ST_IDLE;
                else if (w_last) w_next = ST_SIGN;
            end
            ST_SIGN:    w_next = abort_i ? ST_IDLE : ST_END;
            ST_END:     if (!start_i) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == ST_COMPUTE) || (w_next == ST_SIGN);
            r_done  <= (w_next == ST_END);
        end
    end

    // Datapath: operand capture, shift-add iterations and signed result load.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_mcand  <= PW'(w_a_mag);
                        r_mplier <= w_b_mag;
                        r_sign   <= w_a_neg ^ w_b_neg;
                    end
                end
                ST_COMPUTE: begin
                    if (!abort_i) begin
                        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + CNT_W'(1);
                    end
                end
                ST_SIGN: begin
                    if (!abort_i) r_product <= r_sign ? (PW'(0) - r_acc) : r_acc;
                end
                default: ;
            endcase
        end
    end

    assign product_o = r_product;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign state_o   = r_state;

endmodule

// File: tb/tb_mult_seq_n.sv
// Scoreboard bench for mult_seq_n at WIDTH=4 and WIDTH=8 against an integer-arithmetic model.
module tb_mult_seq_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start8, abort, sgn;
    logic [7:0]  a, b;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic        busy4, done4, busy8, done8;
    logic [2:0]  st4, st8;

    int n_checks = 0;
    int n_pass   = 0;
    longint unsigned q4[$];
    longint unsigned q8[$];
    logic pd4 = 1'b0;
    logic pd8 = 1'b0;

    always #5 clk = ~clk;

    mult_seq_n #(.WIDTH(4)) u4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .abort_i(abort), .signed_i(sgn),
        .a_i(a[3:0]), .b_i(b[3:0]), .product_o(p4), .busy_o(busy4), .done_o(done4), .state_o(st4)
    );

    mult_seq_n #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .abort_i(abort), .signed_i(sgn),
        .a_i(a), .b_i(b), .product_o(p8), .busy_o(busy8), .done_o(done8), .state_o(st8)
    );

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Interpret operands as integers, multiply, wrap to 2*w bits.
    function automatic longint unsigned ref_mul(input int w, input bit s,
                                                input longint unsigned x, input longint unsigned y);
        longint unsigned m;
        longint sx, sy, p;
        m  = (64'd1 << w) - 64'd1;
        x  = x & m;
        y  = y & m;
        sx = (s && x[w-1]) ? longint'(x) - (longint'(1) << w) : longint'(x);
        sy = (s && y[w-1]) ? longint'(y) - (longint'(1) << w) : longint'(y);
        p  = sx * sy;
        return longint'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic logic done_of(input int k);
        return (k != 0) ? done8 : done4;
    endfunction

    function automatic logic [2:0] st_of(input int k);
        return (k != 0) ? st8 : st4;
    endfunction

    // Monitor: every rising done_o must match the oldest expected product.
    always @(negedge clk) begin
        if (done4 && !pd4) begin
            if (q4.size() == 0) begin
                n_checks++;
                $display("FAIL w4 unexpected done: product 0x%0h with empty queue", p4);
            end else chk("w4 product", 64'(p4), q4.pop_front());
        end
        if (done8 && !pd8) begin
            if (q8.size() == 0) begin
                n_checks++;
                $display("FAIL w8 unexpected done: product 0x%0h with empty queue", p8);
            end else chk("w8 product", 64'(p8), q8.pop_front());
        end
        pd4 = done4;
        pd8 = done8;
    end

    // One operation: operands scrambled after capture, optional start hold through ST_END.
    task automatic do_op(input int k, input bit s, input longint unsigned x,
                         input longint unsigned y, input int hold);
        int  w;
        int  edges;
        bit  seen;
        w     = (k != 0) ? 8 : 4;
        edges = 0;
        seen  = 1'b0;
        @(negedge clk);
        sgn = s;
        a   = 8'(x);
        b   = 8'(y);
        if (k != 0) begin q8.push_back(ref_mul(8, s, x, y)); start8 = 1'b1; end
        else        begin q4.push_back(ref_mul(4, s, x, y)); start4 = 1'b1; end
        @(posedge clk); #1;
        if (hold == 0) begin start4 = 1'b0; start8 = 1'b0; end
        chk("state after capture", 64'(st_of(k)), 64'd1);
        for (int i = 0; i < 50 && !seen; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            sgn = 1'($urandom);
            @(posedge clk); #1;
            edges++;
            if (done_of(k)) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL done timeout: no done within %0d edges (width %0d)", edges, w);
        end else chk("latency edges incl capture", 64'(edges + 1), 64'(w + 2));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("held done", 64'(done_of(k)), 64'd1);
            chk("held state", 64'(st_of(k)), 64'd3);
        end
        start4 = 1'b0;
        start8 = 1'b0;
        @(posedge clk); #1;
        chk("idle after end", 64'(st_of(k)), 64'd0);
        chk("done low in idle", 64'(done_of(k)), 64'd0);
    endtask

    initial begin
        logic [7:0] prev;
        bit         bad;
        rst = 1'b0; start4 = 1'b0; start8 = 1'b0; abort = 1'b0; sgn = 1'b0; a = '0; b = '0;
        #2;
        chk("reset state4", 64'(st4), 64'd0);
        chk("reset product4", 64'(p4), 64'd0);
        chk("reset busy4", 64'(busy4), 64'd0);
        chk("reset done4", 64'(done4), 64'd0);
        chk("reset state8", 64'(st8), 64'd0);
        chk("reset product8", 64'(p8), 64'd0);
        @(negedge clk) rst = 1'b1;

        do_op(0, 1'b0, 15, 15, 0);         // 225
        do_op(0, 1'b1, 8, 8, 0);           // -8 * -8 = 64
        do_op(0, 1'b1, 13, 5, 0);          // -3 * 5 = 0xF1
        do_op(1, 1'b1, 8'h80, 8'h7F, 0);   // 0xC080
        do_op(0, 1'b0, 9, 6, 5);           // start held through ST_END

        // Abort on the second compute cycle: result register untouched, no done.
        prev = p4;
        @(negedge clk);
        sgn = 1'b0; a = 8'd7; b = 8'd7; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        chk("compute before abort", 64'(st4), 64'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("state after abort", 64'(st4), 64'd0);
        chk("product kept on abort", 64'(p4), 64'(prev));
        bad = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done4) bad = 1'b1;
        end
        chk("no done after abort", 64'(bad), 64'd0);

        // Reset during ST_SIGN clears outputs without a clock.
        @(negedge clk);
        a = 8'd5; b = 8'd7; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int i = 0; i < 20 && st4 != 3'd2; i++) begin
            @(posedge clk); #1;
        end
        chk("reached sign state", 64'(st4), 64'd2);
        rst = 1'b0;
        #1;
        chk("async reset product", 64'(p4), 64'd0);
        chk("async reset busy", 64'(busy4), 64'd0);
        chk("async reset done", 64'(done4), 64'd0);
        chk("async reset state", 64'(st4), 64'd0);
        @(negedge clk) rst = 1'b1;
        do_op(0, 1'b0, 3, 2, 0);           // 6

        repeat (15) do_op(1, 1'($urandom), 64'($urandom_range(255)), 64'($urandom_range(255)), 0);
        repeat (10) do_op(0, 1'($urandom), 64'($urandom_range(15)), 64'($urandom_range(15)), 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", 64'(q4.size() + q8.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
